xor_decrypt_stage: RTL and testbench

- Downstream consumer of the keystream-byte stage: joins each RC4 keystream byte with the matching ciphertext byte and emits plaintext byte = ks ^ ct.
- Sits between the PRGA keystream output and the output memory writer.
- Counts bytes against a programmed message length, buffers results in a 2-entry output FIFO, and signals completion.

---
 rtl/xor_stage_pkg.sv | 21 ++
 rtl/xor_out_fifo.sv | 57 +++++
 rtl/xor_decrypt_stage.sv | 141 ++++++++++++++
 tb/tb_xor_decrypt_stage.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xor_stage_pkg.sv
// Shared types and constants for the XOR decrypt stage (keystream ^ ciphertext).
package xor_stage_pkg;

    // Message sequencing states of the decrypt stage.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Output buffer is fixed at two entries in this revision.
    localparam int FIFO_DEPTH = 2;
    localparam int FIFO_CNT_W = $clog2(FIFO_DEPTH + 1);

    typedef logic [7:0]            byte_t;
    typedef logic [FIFO_CNT_W-1:0] fifo_cnt_t;

    localparam fifo_cnt_t FIFO_FULL_CNT = fifo_cnt_t'(FIFO_DEPTH);

endpackage

// File: rtl/xor_out_fifo.sv
// Two-entry, 8-bit synchronous FIFO buffering plaintext bytes for the writer.
// Push into a full FIFO and pop from an empty one are ignored.
module xor_out_fifo
    import xor_stage_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push_i,
    input  logic [7:0]            data_i,
    input  logic                  pop_i,
    output logic                  valid_o,
    output logic [7:0]            data_o,
    output logic [FIFO_CNT_W-1:0] cnt_o
);

    byte_t     mem_q [FIFO_DEPTH];
    logic      wr_ptr_q;
    logic      rd_ptr_q;
    fifo_cnt_t cnt_q;

    logic do_push;
    logic do_pop;

    assign do_push = push_i && (cnt_q != FIFO_FULL_CNT);
    assign do_pop  = pop_i  && (cnt_q != '0);

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values of the others, independent of order.
        if (rst) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            if (do_push) wr_ptr_q <= ~wr_ptr_q;
            if (do_pop)  rd_ptr_q <= ~rd_ptr_q;
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + fifo_cnt_t'(1);
                2'b01:   cnt_q <= cnt_q - fifo_cnt_t'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Storage write.
    always_ff @(posedge clk) begin
        // NOTE: the data array is not reset; occupancy alone decides which
        // entries are meaningful and data_o is masked while empty.
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

    assign valid_o = (cnt_q != '0);
    assign data_o  = valid_o ? mem_q[rd_ptr_q] : 8'h00;
    assign cnt_o   = cnt_q;

endmodule

// File: rtl/xor_decrypt_stage.sv
// XOR decrypt stage: joins RC4 keystream and ciphertext bytes, emits
// plaintext through a two-entry FIFO, counts bytes against a programmed
// message length and pulses done_o at the end of each message.
// Optional: define XOR_STAGE_CHECKSUM_EN to add chksum_o, a running XOR
// of the plaintext bytes of the current message.
module xor_decrypt_stage
    import xor_stage_pkg::*;
#(
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [LEN_W-1:0] msg_len_i,
    input  logic             ks_valid_i,
    input  logic [7:0]       ks_data_i,
    output logic             ks_ready_o,
    input  logic             ct_valid_i,
    input  logic [7:0]       ct_data_i,
    output logic             ct_ready_o,
    output logic             pt_valid_o,
    output logic [7:0]       pt_data_o,
    input  logic             pt_ready_i,
    output logic             busy_o,
    output logic             done_o,
`ifdef XOR_STAGE_CHECKSUM_EN
    output logic [7:0]       chksum_o,
`endif
    output logic [LEN_W-1:0] byte_cnt_o
);

    state_e           state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [LEN_W-1:0] cnt_inc;

    logic             fifo_valid;
    logic [7:0]       fifo_data;
    fifo_cnt_t        fifo_cnt;
    logic             fire;
    logic             pop;
    byte_t            pt_byte;

`ifdef XOR_STAGE_CHECKSUM_EN
    byte_t            chk_q, chk_d;
`endif

    // Both operand bytes are consumed together, only in RUN and only when
    // the FIFO has room; rst suppresses everything combinationally so all
    // outputs read 0 for every cycle rst is high.
    assign fire    = !rst && (state_q == ST_RUN) && ks_valid_i && ct_valid_i
                     && (fifo_cnt != FIFO_FULL_CNT);
    assign pop     = !rst && fifo_valid && pt_ready_i;
    assign pt_byte = ks_data_i ^ ct_data_i;
    assign cnt_inc = cnt_q + LEN_W'(1);

    xor_out_fifo u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (fire),
        .data_i  (pt_byte),
        .pop_i   (pop),
        .valid_o (fifo_valid),
        .data_o  (fifo_data),
        .cnt_o   (fifo_cnt)
    );

    // Next-state logic for the message FSM, length latch and byte counter.
    always_comb begin
        // NOTE: every variable gets its hold value first so no path through
        // the case leaves one unassigned, which would infer a latch.
        state_d = state_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
`ifdef XOR_STAGE_CHECKSUM_EN
        chk_d   = chk_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    len_d   = msg_len_i;
                    cnt_d   = '0;
`ifdef XOR_STAGE_CHECKSUM_EN
                    chk_d   = 8'h00;
`endif
                    state_d = (msg_len_i == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (fire) begin
                    cnt_d = cnt_inc;
`ifdef XOR_STAGE_CHECKSUM_EN
                    chk_d = chk_q ^ pt_byte;
`endif
                    // Counter stops at len_q, so it never wraps in a message.
                    if (cnt_inc == len_q) state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!fifo_valid) state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, length and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            len_q   <= '0;
            cnt_q   <= '0;
`ifdef XOR_STAGE_CHECKSUM_EN
            chk_q   <= 8'h00;
`endif
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
`ifdef XOR_STAGE_CHECKSUM_EN
            chk_q   <= chk_d;
`endif
        end
    end

    assign ks_ready_o = fire;
    assign ct_ready_o = fire;
    assign pt_valid_o = !rst && fifo_valid;
    assign pt_data_o  = rst ? 8'h00 : fifo_data;
    assign busy_o     = !rst && ((state_q == ST_RUN) || (state_q == ST_DRAIN));
    assign done_o     = !rst && (state_q == ST_DONE);
    assign byte_cnt_o = rst ? '0 : cnt_q;
`ifdef XOR_STAGE_CHECKSUM_EN
    assign chksum_o   = rst ? 8'h00 : chk_q;
`endif

endmodule

// File: tb/tb_xor_decrypt_stage.sv
// Self-checking bench for xor_decrypt_stage: table-driven byte streams with
// a scoreboard queue of expected plaintext, plus hand-written sequences for
// backpressure, zero length, start during RUN and reset mid-message.
module tb_xor_decrypt_stage;

    localparam int LEN_W = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             start_i;
    logic [LEN_W-1:0] msg_len_i;
    logic             ks_valid_i;
    logic [7:0]       ks_data_i;
    logic             ks_ready_o;
    logic             ct_valid_i;
    logic [7:0]       ct_data_i;
    logic             ct_ready_o;
    logic             pt_valid_o;
    logic [7:0]       pt_data_o;
    logic             pt_ready_i;
    logic             busy_o;
    logic             done_o;
    logic [LEN_W-1:0] byte_cnt_o;
`ifdef XOR_STAGE_CHECKSUM_EN
    logic [7:0]       chksum_o;
`endif

    always #5 clk = ~clk;

    xor_decrypt_stage #(.LEN_W(LEN_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start_i),
        .msg_len_i  (msg_len_i),
        .ks_valid_i (ks_valid_i),
        .ks_data_i  (ks_data_i),
        .ks_ready_o (ks_ready_o),
        .ct_valid_i (ct_valid_i),
        .ct_data_i  (ct_data_i),
        .ct_ready_o (ct_ready_o),
        .pt_valid_o (pt_valid_o),
        .pt_data_o  (pt_data_o),
        .pt_ready_i (pt_ready_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
`ifdef XOR_STAGE_CHECKSUM_EN
        .chksum_o   (chksum_o),
`endif
        .byte_cnt_o (byte_cnt_o)
    );

    typedef struct {
        logic [7:0] ks;
        logic [7:0] ct;
        logic [7:0] pt;
    } vec_t;

    vec_t       vecs [7];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         done_total = 0;
    logic [7:0] exp_q [$];
    int         fire_cyc [$];
    int         out_cyc [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor: scoreboard pop and handshake sanity on the falling edge.
    always @(negedge clk) begin
        if (done_o) done_total++;
        if (ks_ready_o || ct_ready_o) begin
            check("ready_pair", ct_ready_o, ks_ready_o);
            check("ready_needs_both_valid", ks_valid_i && ct_valid_i, 1);
        end
        if (pt_valid_o && pt_ready_i) begin
            out_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL pt_unexpected: got byte %0d expected none", pt_data_o);
            end else begin
                check("pt_data", pt_data_o, exp_q.pop_front());
            end
        end
    end

    // Present one table entry until it is consumed; returns at posedge+1.
    task automatic send_byte(input int i, input bit toggle);
        bit got = 0;
        ks_valid_i = 1'b1;
        ks_data_i  = vecs[i].ks;
        ct_data_i  = vecs[i].ct;
        ct_valid_i = toggle ? 1'b0 : 1'b1;
        for (int n = 0; n < 100 && !got; n++) begin
            @(negedge clk);
            if (ks_ready_o) begin
                got = 1;
                exp_q.push_back(vecs[i].pt);
                fire_cyc.push_back(cyc);
            end
            @(posedge clk);
            #1;
            if (toggle) ct_valid_i = ~ct_valid_i;
        end
        check("fire_seen", got, 1);
        ks_valid_i = 1'b0;
        ct_valid_i = 1'b0;
    endtask

    task automatic start_msg(input logic [LEN_W-1:0] len);
        start_i   = 1'b1;
        msg_len_i = len;
        @(posedge clk);
        #1;
        start_i   = 1'b0;
        msg_len_i = 16'hBEEF;
    endtask

    task automatic wait_done(input int exp_cnt, input logic [7:0] exp_chk);
        bit found = 0;
        for (int n = 0; n < 50 && !found; n++) begin
            @(negedge clk);
            if (done_o) found = 1;
        end
        check("done_seen", found, 1);
        check("done_byte_cnt", byte_cnt_o, exp_cnt);
`ifdef XOR_STAGE_CHECKSUM_EN
        check("chksum", chksum_o, exp_chk);
`else
        check("done_pt_idle", pt_valid_o, 0);
        if (exp_chk === 8'hxx) $display("note: checksum unknown");
`endif
        @(negedge clk);
        check("done_one_cycle", done_o, 0);
        check("byte_cnt_hold", byte_cnt_o, exp_cnt);
        check("busy_after_done", busy_o, 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int         d0;
        logic [7:0] chk;

        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int         d0;
        logic [7:0] chk;

        vecs[0] = '{ks: 8'd44,  ct: 8'd70,  pt: 8'd106};
        vecs[1] = '{ks: 8'd90,  ct: 8'd90,  pt: 8'd0};
        vecs[2] = '{ks: 8'd100, ct: 8'd23,  pt: 8'd115};
        vecs[3] = '{ks: 8'hFF,  ct: 8'h0F,  pt: 8'hF0};
        vecs[4] = '{ks: 8'hA5,  ct: 8'h5A,  pt: 8'hFF};
        vecs[5] = '{ks: 8'h00,  ct: 8'h00,  pt: 8'h00};
        vecs[6] = '{ks: 8'h81,  ct: 8'h3C,  pt: 8'hBD};

        rst = 1'b1; start_i = 1'b0; msg_len_i = '0;
        ks_valid_i = 1'b0; ks_data_i = '0; ct_valid_i = 1'b0; ct_data_i = '0;
        pt_ready_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_busy", busy_o, 0);
        check("reset_pt_valid", pt_valid_o, 0);
        check("reset_byte_cnt", byte_cnt_o, 0);
        @(posedge clk);
        #1;

        // Valid inputs in IDLE are not consumed.
        ks_valid_i = 1'b1; ct_valid_i = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("idle_no_ready", ks_ready_o, 0);
        end
        @(posedge clk);
        #1;
        ks_valid_i = 1'b0; ct_valid_i = 1'b0;

        // Basic three-byte message, continuous valids, no backpressure.
        d0 = done_total; chk = 8'h00;
        fire_cyc.delete(); out_cyc.delete();
        start_msg(3);
        for (int i = 0; i < 3; i++) begin
            send_byte(i, 1'b0);
            chk ^= vecs[i].pt;
            check("running_byte_cnt", byte_cnt_o, i + 1);
        end
        wait_done(3, chk);
        check("s2_done_pulses", done_total - d0, 1);
        check("s2_out_count", out_cyc.size(), 3);
        check("s2_queue_empty", exp_q.size(), 0);
        for (int i = 0; i < 3 && i < out_cyc.size(); i++) begin
            check("s2_latency", out_cyc[i], fire_cyc[i] + 1);
            check("s2_back_to_back", fire_cyc[i], fire_cyc[0] + i);
        end

        // Backpressure: FIFO fills after two bytes, third waits.
        d0 = done_total; chk = 8'h00;
        pt_ready_i = 1'b0;
        start_msg(3);
        send_byte(0, 1'b0);
        send_byte(1, 1'b0);
        ks_valid_i = 1'b1; ct_valid_i = 1'b1;
        ks_data_i = vecs[2].ks; ct_data_i = vecs[2].ct;
        repeat (4) begin
            @(negedge clk);
            check("bp_no_ready", ks_ready_o, 0);
            check("bp_pt_valid", pt_valid_o, 1);
            check("bp_pt_hold", pt_data_o, 106);
            check("bp_byte_cnt", byte_cnt_o, 2);
        end
        @(posedge clk);
        #1;
        pt_ready_i = 1'b1;
        send_byte(2, 1'b0);
        wait_done(3, 8'd25);
        check("bp_done_pulses", done_total - d0, 1);
        check("bp_queue_empty", exp_q.size(), 0);

        // ct_valid toggling: consumption only when both valid.
        d0 = done_total; chk = 8'h00;
        out_cyc.delete();
        start_msg(4);
        for (int i = 3; i < 7; i++) begin
            send_byte(i, 1'b1);
            chk ^= vecs[i].pt;
        end
        wait_done(4, chk);
        check("tog_out_count", out_cyc.size(), 4);
        check("tog_queue_empty", exp_q.size(), 0);

        // Zero-length message goes straight to DONE.
        d0 = done_total;
        out_cyc.delete();
        start_msg(0);
        @(negedge clk);
        check("zero_done", done_o, 1);
        check("zero_pt_valid", pt_valid_o, 0);
        check("zero_byte_cnt", byte_cnt_o, 0);
        @(negedge clk);
        check("zero_done_once", done_o, 0);
        check("zero_done_pulses", done_total - d0, 1);
        check("zero_no_output", out_cyc.size(), 0);
        @(posedge clk);
        #1;

        // start_i during RUN must not reload the length.
        start_msg(2);
        send_byte(0, 1'b0);
        start_i = 1'b1; msg_len_i = 16'd9;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        send_byte(1, 1'b0);
        wait_done(2, vecs[0].pt ^ vecs[1].pt);

        // Reset mid-message with a full FIFO.
        pt_ready_i = 1'b0;
        start_msg(5);
        send_byte(3, 1'b0);
        send_byte(4, 1'b0);
        d0 = done_total;
        out_cyc.delete();
        ks_valid_i = 1'b1; ct_valid_i = 1'b1;
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("rst_pt_valid", pt_valid_o, 0);
            check("rst_pt_data", pt_data_o, 0);
            check("rst_ks_ready", ks_ready_o, 0);
            check("rst_ct_ready", ct_ready_o, 0);
            check("rst_busy", busy_o, 0);
            check("rst_done", done_o, 0);
            check("rst_byte_cnt", byte_cnt_o, 0);
`ifdef XOR_STAGE_CHECKSUM_EN
            check("rst_chksum", chksum_o, 0);
`endif
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        ks_valid_i = 1'b0; ct_valid_i = 1'b0;
        exp_q.delete();
        pt_ready_i = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("post_rst_fifo_empty", pt_valid_o, 0);
            check("post_rst_idle", busy_o, 0);
        end
        check("post_rst_no_done", done_total - d0, 0);
        check("post_rst_no_output", out_cyc.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
